// File: rtl/life_step_controller.sv
// life_step_controller
// Computes one Game-of-Life (B3/S23) generation over a SIDE x SIDE grid held
// in an external bit memory. Each cell is visited with 9 read slots (self,
// then NW, N, NE, W, E, SW, S, SE) plus one decide cycle; the next generation
// accumulates in a shadow line and is bulk-loaded in a single init cycle.
//
// Build option: define LIFE_WRAP_EN for a toroidal grid (neighbour
// coordinates wrap modulo SIDE, every slot is a real read). Without it,
// off-grid neighbours are dead and their slot drives read=0, index=0.
// Timing is identical in both builds: memSize*10 + 2 cycles per step.
module life_step_controller #(
  parameter int size    = 5,
  parameter int memSize = 25,
  parameter int SIDE    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mem_out,
  output logic [size-1:0]    index,
  output logic               read,
  output logic               init,
  output logic [memSize-1:0] line,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {IDLE, SCAN, DECIDE, COMMIT, DONE} state_t;

  localparam logic signed [size+1:0] P1     = (size+2)'(1);
  localparam logic signed [size+1:0] M1     = (size+2)'(-1);
  localparam logic signed [size+1:0] SIDE_S = (size+2)'(SIDE);
  localparam logic [size-1:0]        SIDE_U = size'(SIDE);
  localparam logic [size-1:0]        LAST_C = size'(SIDE - 1);
  localparam logic [size-1:0]        LAST   = size'(memSize - 1);

  state_t               r_state, w_state_nxt;
  logic [size-1:0]      r_cell, r_row, r_col;
  logic [3:0]           r_slot;
  logic [3:0]           r_cnt;
  logic                 r_self;
  logic [memSize-1:0]   r_shadow;

  logic signed [size+1:0] w_dr, w_dc, w_nr, w_nc;
  logic                   w_row_ok, w_col_ok, w_in_grid;
  logic [size-1:0]        w_r, w_c, w_idx;
  logic                   w_next;

  // Neighbour coordinate for the current slot and its memory index
  always_comb begin
    w_dr = '0;
    w_dc = '0;
    case (r_slot)
      4'd1: begin w_dr = M1; w_dc = M1; end   // NW
      4'd2: begin w_dr = M1; w_dc = '0; end   // N
      4'd3: begin w_dr = M1; w_dc = P1; end   // NE
      4'd4: begin w_dr = '0; w_dc = M1; end   // W
      4'd5: begin w_dr = '0; w_dc = P1; end   // E
      4'd6: begin w_dr = P1; w_dc = M1; end   // SW
      4'd7: begin w_dr = P1; w_dc = '0; end   // S
      4'd8: begin w_dr = P1; w_dc = P1; end   // SE
      default: ;                              // slot 0: the cell itself
    endcase
    w_nr     = $signed({2'b00, r_row}) + w_dr;
    w_nc     = $signed({2'b00, r_col}) + w_dc;
    w_row_ok = !w_nr[size+1] && (w_nr < SIDE_S);
    w_col_ok = !w_nc[size+1] && (w_nc < SIDE_S);
`ifdef LIFE_WRAP_EN
    // Modular add/sub in size bits folds -1 to SIDE-1 and SIDE to 0
    w_in_grid = 1'b1;
    if (w_nr[size+1])  w_r = w_nr[size-1:0] + SIDE_U;
    else if (!w_row_ok) w_r = w_nr[size-1:0] - SIDE_U;
    else                w_r = w_nr[size-1:0];
    if (w_nc[size+1])  w_c = w_nc[size-1:0] + SIDE_U;
    else if (!w_col_ok) w_c = w_nc[size-1:0] - SIDE_U;
    else                w_c = w_nc[size-1:0];
`else
    w_in_grid = w_row_ok && w_col_ok;
    w_r       = w_nr[size-1:0];
    w_c       = w_nc[size-1:0];
`endif
    w_idx = w_r * SIDE_U + w_c;
  end

  // B3/S23 rule on the accumulated neighbour count
  always_comb begin
    if (r_self) w_next = (r_cnt == 4'd2) || (r_cnt == 4'd3);
    else        w_next = (r_cnt == 4'd3);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and memory-side outputs
  always_comb begin
    w_state_nxt = r_state;
    index       = '0;
    read        = 1'b0;
    init        = 1'b0;
    line        = '0;
    busy        = (r_state != IDLE);
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = SCAN;
      end
      SCAN: begin
        if (w_in_grid) begin
          read  = 1'b1;
          index = w_idx;
        end
        if (r_slot == 4'd8) w_state_nxt = DECIDE;
      end
      DECIDE: begin
        if (r_cell == LAST) w_state_nxt = COMMIT;
        else                w_state_nxt = SCAN;
      end
      COMMIT: begin
        init        = 1'b1;
        line        = r_shadow;
        w_state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Scan datapath: cell/row/col/slot counters, self bit, neighbour count, shadow
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cell   <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_slot   <= '0;
      r_cnt    <= '0;
      r_self   <= 1'b0;
      r_shadow <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_cell   <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_slot   <= '0;
            r_cnt    <= '0;
            r_self   <= 1'b0;
            r_shadow <= '0;
          end
        end
        SCAN: begin
          if (r_slot == 4'd0)  r_self <= mem_out;
          else if (w_in_grid)  r_cnt  <= r_cnt + {3'b000, mem_out};
          r_slot <= (r_slot == 4'd8) ? 4'd0 : r_slot + 4'd1;
        end
        DECIDE: begin
          r_shadow[r_cell] <= w_next;
          r_cnt            <= '0;
          if (r_cell != LAST) begin
            r_cell <= r_cell + 1'b1;
            if (r_col == LAST_C) begin
              r_col <= '0;
              r_row <= r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_life_step_controller.sv
// Directed bench for life_step_controller with a behavioural 25-bit memory.
module tb_life_step_controller;

  logic        clk = 1'b0;
  logic        rst, start, mem_out;
  logic [4:0]  index;
  logic        read, init;
  logic [24:0] line;
  logic        busy, done;

  life_step_controller #(.size(5), .memSize(25), .SIDE(5)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_out(mem_out),
    .index(index), .read(read), .init(init), .line(line),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Memory model: bulk load from bench or from the DUT init strobe
  logic [24:0] mem, ld_val;
  logic        ld;
  always @(posedge clk) begin
    if (ld)        mem <= ld_val;
    else if (init) mem <= line;
  end
  assign mem_out = (index < 5'd25) ? mem[index] : 1'b0;

  int checks, failures;

  bit [600:0]  init_log, done_log, busy_log, read_log;
  logic [4:0]  idx_log [0:9];
  logic [24:0] line_at_init;
  bit          zero_after;

  task automatic load_mem(input logic [24:0] v);
    @(negedge clk);
    ld = 1'b1; ld_val = v;
    @(posedge clk);
    #1 ld = 1'b0;
  endtask

  // Pulse start, then log outputs mid-cycle for n_max cycles. Cycle n=1 is the
  // first cycle after the accepting edge. start is driven high during cycles
  // s_lo..s_hi, rst during cycle r_at.
  task automatic run_gen(input int s_lo, input int s_hi, input int r_at, input int n_max);
    init_log = '0; done_log = '0; busy_log = '0; read_log = '0;
    line_at_init = '0; zero_after = 1'b0;
    for (int k = 0; k < 10; k++) idx_log[k] = '0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= n_max; n++) begin
      init_log[n] = init; done_log[n] = done;
      busy_log[n] = busy; read_log[n] = read;
      if (n < 10) idx_log[n] = index;
      if (init) line_at_init = line;
      if (n == r_at + 1)
        zero_after = (index == 5'd0) && !read && !init && (line == 25'd0) && !busy && !done;
      start = (n >= s_lo) && (n <= s_hi);
      rst   = (n == r_at);
      @(negedge clk);
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    ld = 1'b1; ld_val = 25'd0;
    repeat (3) @(negedge clk);
    ld = 1'b0;
    checks++;
    if (index !== 5'd0 || read !== 1'b0 || init !== 1'b0) begin
      failures++; $display("FAIL reset_mem_port got idx=%0d read=%b init=%b exp 0/0/0", index, read, init);
    end
    checks++;
    if (line !== 25'd0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL reset_status got line=%h busy=%b done=%b exp 0/0/0", line, busy, done);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL idle_no_start got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_blinker();
    bit busy_ok;
    load_mem(25'h0003800);
    run_gen(1000, 0, -5, 260);
    checks++;
    if ($countones(init_log) != 1 || init_log[251] !== 1'b1) begin
      failures++; $display("FAIL blinker_init_timing got count=%0d at251=%b exp 1/1", $countones(init_log), init_log[251]);
    end
    checks++;
    if (line_at_init !== 25'h0021080) begin
      failures++; $display("FAIL blinker_line got=%h exp=%h", line_at_init, 25'h0021080);
    end
    checks++;
    if ($countones(done_log) != 1 || done_log[252] !== 1'b1) begin
      failures++; $display("FAIL blinker_done_timing got count=%0d at252=%b exp 1/1", $countones(done_log), done_log[252]);
    end
    busy_ok = 1'b1;
    for (int n = 1; n <= 252; n++) if (!busy_log[n]) busy_ok = 1'b0;
    checks++;
    if (!busy_ok || busy_log[253] !== 1'b0) begin
      failures++; $display("FAIL blinker_busy got span_ok=%b at253=%b exp 1/0", busy_ok, busy_log[253]);
    end
    checks++;
    if (mem !== 25'h0021080) begin
      failures++; $display("FAIL blinker_mem got=%h exp=%h", mem, 25'h0021080);
    end
    run_gen(1000, 0, -5, 260);
    checks++;
    if (line_at_init !== 25'h0003800 || mem !== 25'h0003800) begin
      failures++; $display("FAIL blinker_second got line=%h mem=%h exp=%h", line_at_init, mem, 25'h0003800);
    end
  endtask

  task automatic test_still_life();
    load_mem(25'h00018C0);
    run_gen(1000, 0, -5, 260);
    checks++;
    if (line_at_init !== 25'h00018C0 || !init_log[251]) begin
      failures++; $display("FAIL block_line got=%h init251=%b exp=%h/1", line_at_init, init_log[251], 25'h00018C0);
    end
    load_mem(25'h0000000);
    run_gen(1000, 0, -5, 260);
    checks++;
    if (line_at_init !== 25'h0000000 || !init_log[251] || mem !== 25'h0000000) begin
      failures++; $display("FAIL empty_line got=%h init251=%b mem=%h exp 0/1/0", line_at_init, init_log[251], mem);
    end
  endtask

  task automatic test_edge();
    logic [8:0]  rp;
    logic [24:0] exp_line;
    logic [8:0]  exp_rp;
    logic [4:0]  exp_nw;
`ifdef LIFE_WRAP_EN
    exp_line = 25'h0004C00; exp_rp = 9'h1FF; exp_nw = 5'd24;
`else
    exp_line = 25'h0000C00; exp_rp = 9'h1A1; exp_nw = 5'd0;
`endif
    load_mem(25'h0008420);
    run_gen(1000, 0, -5, 260);
    for (int k = 0; k < 9; k++) rp[k] = read_log[k+1];
    checks++;
    if (line_at_init !== exp_line) begin
      failures++; $display("FAIL edge_line got=%h exp=%h", line_at_init, exp_line);
    end
    checks++;
    if (rp !== exp_rp) begin
      failures++; $display("FAIL corner_read_slots got=%h exp=%h", rp, exp_rp);
    end
    checks++;
    if (idx_log[1] !== 5'd0 || idx_log[6] !== 5'd1 || idx_log[9] !== 5'd6) begin
      failures++; $display("FAIL corner_index got self=%0d E=%0d SE=%0d exp 0/1/6", idx_log[1], idx_log[6], idx_log[9]);
    end
    checks++;
    if (idx_log[2] !== exp_nw) begin
      failures++; $display("FAIL corner_nw_index got=%0d exp=%0d", idx_log[2], exp_nw);
    end
  endtask

  task automatic test_reset_mid();
    load_mem(25'h0003800);
    run_gen(1000, 0, 100, 300);
    checks++;
    if (!zero_after) begin
      failures++; $display("FAIL midreset_outputs got nonzero exp all zero");
    end
    checks++;
    if ($countones(init_log) != 0 || $countones(done_log) != 0) begin
      failures++; $display("FAIL midreset_no_commit got init=%0d done=%0d exp 0/0", $countones(init_log), $countones(done_log));
    end
    checks++;
    if (mem !== 25'h0003800) begin
      failures++; $display("FAIL midreset_mem got=%h exp=%h", mem, 25'h0003800);
    end
    run_gen(1000, 0, -5, 260);
    checks++;
    if (line_at_init !== 25'h0021080 || !init_log[251] || !done_log[252]) begin
      failures++; $display("FAIL midreset_restart got line=%h i251=%b d252=%b exp %h/1/1", line_at_init, init_log[251], done_log[252], 25'h0021080);
    end
  endtask

  task automatic test_start_while_busy();
    load_mem(25'h0003800);
    run_gen(50, 50, -5, 520);
    checks++;
    if ($countones(init_log) != 1 || !init_log[251]) begin
      failures++; $display("FAIL busy_start_init got count=%0d at251=%b exp 1/1", $countones(init_log), init_log[251]);
    end
    checks++;
    if ($countones(done_log) != 1 || !done_log[252]) begin
      failures++; $display("FAIL busy_start_done got count=%0d at252=%b exp 1/1", $countones(done_log), done_log[252]);
    end
  endtask

  task automatic test_back_to_back();
    load_mem(25'h0003800);
    run_gen(252, 253, -5, 520);
    checks++;
    if (busy_log[253] !== 1'b0 || busy_log[254] !== 1'b1) begin
      failures++; $display("FAIL b2b_busy got at253=%b at254=%b exp 0/1", busy_log[253], busy_log[254]);
    end
    checks++;
    if ($countones(init_log) != 2 || !init_log[251] || !init_log[504]) begin
      failures++; $display("FAIL b2b_init got count=%0d i251=%b i504=%b exp 2/1/1", $countones(init_log), init_log[251], init_log[504]);
    end
    checks++;
    if (!done_log[505] || mem !== 25'h0003800) begin
      failures++; $display("FAIL b2b_result got d505=%b mem=%h exp 1/%h", done_log[505], mem, 25'h0003800);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; start = 1'b0; ld = 1'b0; ld_val = '0;
    test_reset();
    test_blinker();
    test_still_life();
    test_edge();
    test_reset_mid();
    test_start_while_busy();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/life_step_controller.md
Name: life_step_controller

Overview:
- Sequencer directly upstream of the 25-cell bit memory: computes one Game-of-Life generation over the SIDE x SIDE grid held in that memory.
- Reads each cell and its neighbours one bit per cycle through the memory's index/read port and accumulates the next generation in an internal shadow line.
- Commits the whole next generation in one cycle via the memory's init/line bulk-load path, then pulses done.

Parameters:
- size, 5, width of index bus
- memSize, 25, number of cells / width of line bus (must equal SIDE*SIDE)
- SIDE, 5, grid edge length; cell i sits at row i/SIDE, col i%SIDE

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset (synchronous, active-high)
- start  input  1  request one generation step; sampled only in IDLE
- mem_out  input  1  cell bit returned by memory (combinational, valid same cycle as read=1)
- index  output  size  cell address driven to memory
- read  output  1  memory read strobe
- init  output  1  one-cycle bulk-load strobe to memory
- line  output  memSize  next-generation image; valid while init=1
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle completion pulse

Behaviour:
- One clock. Reset is synchronous and active-high: on a clk edge with rst=1 → state IDLE; index, read, init, busy, done = 0; line = 0; shadow line, cell counter, slot counter and neighbour count = 0.
- rst mid-operation: aborts immediately; init is never asserted for the aborted step; memory contents unchanged.
- States: IDLE, SCAN, DECIDE, COMMIT, DONE.
- IDLE: start=1 → SCAN with cell=0, slot=0, busy=1. start=0 → stay.
- SCAN: 9 slots per cell, one per cycle.
  - Slot 0 reads the cell itself.
  - Slots 1-8 read neighbours in fixed order NW, N, NE, W, E, SW, S, SE.
  - Index for an in-grid slot is row*SIDE+col; read=1; mem_out is sampled at the cycle's end edge.
  - Out-of-grid neighbour (edge/corner): read=0, index=0, contributes 0, but still consumes its cycle. Timing is fixed regardless of position.
  - Neighbour count is 4 bits and is never saturated.
  - After slot 8 → DECIDE.
- DECIDE (1 cycle, read=0):
  - next = (self & (cnt==2 | cnt==3)) | (~self & cnt==3), i.e. rule B3/S23.
  - Write next to shadow[cell]; clear cnt.
  - If cell==memSize-1 → COMMIT; else cell+1 → SCAN.
- COMMIT (1 cycle): init=1, line=shadow. Memory loads on this edge.
- DONE (1 cycle): done=1, busy still 1. Next cycle → IDLE with busy=0, line=0.
- Latency: start accepted at edge t → init high during cycle t+251 → done high during cycle t+252. Total = memSize*10 + 2 cycles.
- start while busy: ignored, not queued.
- start held high across DONE: new step begins on the first IDLE cycle.
- Memory is never written mid-scan. The scan therefore always sees generation N, never a partial N+1.
- The memory's single-bit write port is unused by this block and tied low at integration.

Optional Feature:
- Macro LIFE_WRAP_EN.
- Defined: toroidal grid. Out-of-grid neighbour coordinates wrap modulo SIDE, so every slot is a real read (read=1 on all 9 slots).
- Undefined: boundary cells are treated as dead, and out-of-grid slots assert read=0 as above.
- Latency is identical in both builds.

Test Plan:
- Blinker: memory=0x0003800 (bits 11,12,13), pulse start → init once at start+251 with line=0x0021080 (bits 7,12,17), done at start+252; second step restores 0x0003800.
- Still life: memory=0x00018C0 (bits 6,7,11,12) → line=0x00018C0; empty grid 0x0000000 → line=0x0000000.
- Edge, LIFE_WRAP_EN undefined: memory bits 5,10,15 (0x0008420) → line=0x0000C00; corner slots (cell 0: NW,N,NE,W,SW) show read=0.
- Edge, LIFE_WRAP_EN defined: same input 0x0008420 → line=0x0004C00; read=1 on all 9 slots of every cell.
- Reset mid-scan: assert rst at start+100 for one cycle → all outputs 0 next cycle, init never pulses, memory still holds the original image; a fresh start then completes normally.
- start re-asserted at start+50 while busy → no effect; exactly one init pulse and one done pulse, at +251 and +252.
